pid_controller: RTL and testbench

Discrete PD velocity controller for the BLDC drive path. It samples an 8-bit measured velocity, forms the error against a fixed setpoint, and combines the proportional and derivative terms using 4-bit run-time gains. The result is an 8-bit saturated drive command for the downstream PWM/commutation logic. Updates occur only on clock-enable cycles.

---
 rtl/pid_pkg.sv | 24 ++
 rtl/pid_sat_u8.sv | 11 +
 rtl/pid_controller.sv | 94 +++++++++
 tb/tb_pid_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared widths, signed types and the unsigned-8 saturation helper for the PD(I) velocity controller.
package pid_pkg;

  localparam int VEL_W   = 8;
  localparam int GAIN_W  = 4;
  localparam int ERR_W   = 9;
  localparam int DERIV_W = 10;
  localparam int ACC_W   = 16;

  typedef logic signed [ERR_W-1:0]   err_t;
  typedef logic signed [DERIV_W-1:0] deriv_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  function automatic logic [VEL_W-1:0] sat_u8(input acc_t v);
    if (v < acc_t'(0)) begin
      return '0;
    end else if (v > acc_t'(255)) begin
      return {VEL_W{1'b1}};
    end else begin
      return v[VEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pid_sat_u8.sv
// Combinational clamp of a signed 16-bit control value onto the 0..255 drive range.
module pid_sat_u8
  import pid_pkg::*;
(
  input  logic [ACC_W-1:0] din,
  output logic [VEL_W-1:0] dout
);

  assign dout = sat_u8($signed(din));

endmodule

// File: rtl/pid_controller.sv
// PD velocity controller with registered, saturated 8-bit drive output.
// Defining PID_INTEGRAL_EN adds a clamped integral term (anti-windup).
module pid_controller
  import pid_pkg::*;
#(
  parameter int SETPOINT   = 128,
  parameter int OUT_OFFSET = 128,
  parameter int SHIFT      = 2,
  parameter int KI_SHIFT   = 4,
  parameter int INT_LIMIT  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [VEL_W-1:0] current_vel,
  input  logic [GAIN_W-1:0] kp,
  input  logic [GAIN_W-1:0] kd,
  output logic [VEL_W-1:0] vel_output
);

  localparam err_t SP = err_t'(SETPOINT);

  err_t             e;
  err_t             prev_error;
  deriv_t           d;
  acc_t             p;
  acc_t             q;
  acc_t             u;
  acc_t             s;
  acc_t             r;
  logic [VEL_W-1:0] sat_val;

`ifdef PID_INTEGRAL_EN
  localparam acc_t INT_MAX = acc_t'(INT_LIMIT);
  localparam acc_t INT_MIN = acc_t'(-INT_LIMIT);

  acc_t integ;
  acc_t integ_sum;
  acc_t integ_next;

  always_comb begin
    integ_sum = integ + acc_t'(e);
    if (integ_sum > INT_MAX) begin
      integ_next = INT_MAX;
    end else if (integ_sum < INT_MIN) begin
      integ_next = INT_MIN;
    end else begin
      integ_next = integ_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ <= '0;
    end else if (ce) begin
      integ <= integ_next;
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = KI_SHIFT ^ INT_LIMIT;
`endif

  // Every operand is widened before combining so no intermediate can wrap.
  always_comb begin
    e = SP - err_t'({1'b0, current_vel});
    d = deriv_t'(e) - deriv_t'(prev_error);
    p = acc_t'(e) * acc_t'($signed({1'b0, kp}));
    q = acc_t'(d) * acc_t'($signed({1'b0, kd}));
`ifdef PID_INTEGRAL_EN
    u = p + q + (integ >>> KI_SHIFT);
`else
    u = p + q;
`endif
    s = u >>> SHIFT;
    r = s + acc_t'(OUT_OFFSET);
  end

  pid_sat_u8 u_sat (
    .din  (r),
    .dout (sat_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel_output <= '0;
      prev_error <= '0;
    end else if (ce) begin
      vel_output <= sat_val;
      prev_error <= e;
    end
  end

endmodule

// File: tb/tb_pid_controller.sv
// Self-checking bench for pid_controller: vector table, reset/derivative sequences, random vs. reference model.
module tb_pid_controller;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [7:0] current_vel;
  logic [3:0] kp;
  logic [3:0] kd;
  logic [7:0] vel_output;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // model state
  int m_prev = 0;
  int m_integ = 0;
  int m_out = 0;

  typedef struct {
    logic       ce;
    logic [7:0] vel;
    logic [3:0] kp;
    logic [3:0] kd;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  pid_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .current_vel (current_vel),
    .kp          (kp),
    .kd          (kd),
    .vel_output  (vel_output)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  task automatic check(input string name);
    logic [7:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (vel_output !== exp) begin
      errors++;
      $display("FAIL %s: vel_output=%0d expected=%0d", name, vel_output, exp);
    end
  endtask

  // driver: apply inputs for one edge, check one cycle later
  task automatic apply(input logic c, input logic [7:0] v, input logic [3:0] p,
                       input logic [3:0] dd, input logic [7:0] exp, input string name);
    ce = c;
    current_vel = v;
    kp = p;
    kd = dd;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    check(name);
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(8'd0);
    check(name);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_prev = 0;
    m_integ = 0;
    m_out = 0;
  endtask

  function automatic int floordiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // reference model: one control step straight from the controller's equations
  task automatic model_step(input logic c, input int v, input int p, input int dd);
    int e;
    int u;
    if (c) begin
      e = 128 - v;
      u = p * e + dd * (e - m_prev);
`ifdef PID_INTEGRAL_EN
      u = u + floordiv(m_integ, 16);
      m_integ = clampi(m_integ + e, -1024, 1024);
`endif
      m_prev = e;
      m_out = clampi(floordiv(u, 4) + 128, 0, 255);
    end
  endtask

  initial begin
    logic       rc;
    logic [7:0] rv;
    logic [3:0] rp;
    logic [3:0] rd;

    vecs[0]  = '{1'b1, 8'd0,   4'd0,  4'd0,  8'd128}; // zero gains -> offset only
    vecs[1]  = '{1'b1, 8'd100, 4'd4,  4'd0,  8'd156}; // proportional
    vecs[2]  = '{1'b1, 8'd0,   4'd15, 4'd0,  8'd255}; // r=608 saturates high
    vecs[3]  = '{1'b1, 8'd255, 4'd15, 4'd0,  8'd0};   // s=-477 saturates low
    vecs[4]  = '{1'b1, 8'd120, 4'd0,  4'd2,  8'd195}; // d=8-(-127)=135
    vecs[5]  = '{1'b1, 8'd120, 4'd0,  4'd2,  8'd128}; // d=0
    vecs[6]  = '{1'b0, 8'd0,   4'd15, 4'd0,  8'd128}; // ce low: hold
    vecs[7]  = '{1'b0, 8'd255, 4'd15, 4'd15, 8'd128};
    vecs[8]  = '{1'b1, 8'd100, 4'd0,  4'd1,  8'd133}; // d=28-8 uses pre-hold prev_error
    vecs[9]  = '{1'b1, 8'd129, 4'd1,  4'd0,  8'd127}; // -1>>>2 = -1
    vecs[10] = '{1'b1, 8'd130, 4'd3,  4'd0,  8'd126}; // -6>>>2 = -2 (floor)
    vecs[11] = '{1'b1, 8'd1,   4'd4,  4'd0,  8'd255}; // r=255 exactly
    vecs[12] = '{1'b1, 8'd0,   4'd4,  4'd0,  8'd255}; // r=256 clamps
    vecs[13] = '{1'b1, 8'd192, 4'd8,  4'd0,  8'd0};   // r=0 exactly

    rst_n = 1'b0;
    ce = 1'b0;
    current_vel = '0;
    kp = '0;
    kd = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(8'd0);
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

`ifndef PID_INTEGRAL_EN
    foreach (vecs[i]) begin
      apply(vecs[i].ce, vecs[i].vel, vecs[i].kp, vecs[i].kd, vecs[i].exp,
            $sformatf("vec%0d", i));
    end
`endif

    // async reset mid-run with ce high and a nonzero output
    apply(1'b1, 8'd0, 4'd4, 4'd0, 8'd255, "pre_reset");
    async_reset("async_reset");
    apply(1'b1, 8'd120, 4'd0, 4'd2, 8'd132, "deriv_first");
    apply(1'b1, 8'd120, 4'd0, 4'd2, 8'd128, "deriv_second");
    async_reset("async_reset2");
    apply(1'b1, 8'd0, 4'd0, 4'd0, 8'd128, "post_reset_first");

    // randomized against the reference model
    async_reset("async_reset3");
    for (int n = 0; n < 400; n++) begin
      rc = ($urandom_range(0, 3) != 0);
      rv = 8'($urandom_range(0, 255));
      rp = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      model_step(rc, int'(rv), int'(rp), int'(rd));
      apply(rc, rv, rp, rd, 8'(m_out), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
